// File: rtl/bid_requester_if.sv
// Bid requester bus bundle.
// Groups the request handshake, the arbiter bid/grant pair and the transfer
// status outputs of one bid_requester instance.
//   slave  : used by bid_requester (takes requests and grant, drives bid/status)
//   master : used by the request source / arbiter side
//   req_valid/req_ready/req_pri/req_len : request handshake
//   grant/bid                           : arbiter connection
//   xfer_valid/xfer_last/done           : burst progress
//   starved/spur_grant/balance          : status
interface bid_requester_if #(
  parameter int unsigned BID_W = 4,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned BAL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic [BID_W-1:0] req_pri;
  logic [LEN_W-1:0] req_len;
  logic             grant;
  logic [BID_W-1:0] bid;
  logic             xfer_valid;
  logic             xfer_last;
  logic             done;
  logic             starved;
  logic             spur_grant;
  logic [BAL_W-1:0] balance;

  modport slave (
    input  req_valid, req_pri, req_len, grant,
    output req_ready, bid, xfer_valid, xfer_last, done, starved, spur_grant, balance
  );

  modport master (
    output req_valid, req_pri, req_len, grant,
    input  req_ready, bid, xfer_valid, xfer_last, done, starved, spur_grant, balance
  );
endinterface

// File: rtl/bid_requester.sv
// Master-side companion to the 4-master weighted bid arbiter.
// Accepts one request (priority + beat count) at a time, bids toward the
// arbiter, runs the burst while granted (resuming after pre-emption), mirrors
// the arbiter's balance accounting and flags starvation.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bid_requester_if.slave (request handshake, grant/bid, status)
module bid_requester #(
  parameter int unsigned BID_W         = 4,
  parameter int unsigned LEN_W         = 4,
  parameter int unsigned BAL_W         = 10,
  parameter int unsigned BAL_INIT      = 750,
  parameter int unsigned REFILL_PERIOD = 400,
  parameter int unsigned REFILL_AMT    = 750,
  parameter int unsigned BAL_CAP       = 900,
  parameter int unsigned STARVE_LIMIT  = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  bid_requester_if.slave bus
);

  localparam int unsigned REF_W  = $clog2(REFILL_PERIOD + 1);
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [REF_W-1:0]  REF_LAST    = REF_W'(REFILL_PERIOD);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(STARVE_LIMIT);
  localparam logic [BAL_W:0]    AMT_X       = (BAL_W+1)'(REFILL_AMT);
  localparam logic [BAL_W:0]    CAP_X       = (BAL_W+1)'(BAL_CAP);
  localparam logic [BAL_W-1:0]  BID_MAX_BAL = BAL_W'((2**BID_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    BID,
    XFER
  } state_e;

  state_e            state_q, state_d;
  logic [BID_W-1:0]  pri_q, pri_d;
  logic [BID_W-1:0]  bid_q, bid_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starved_q, starved_d;
  logic              done_q, done_d;
  logic              spur_q, spur_d;
  logic              ready_q, ready_d;

  logic              beat;
  logic              refill;
  logic [BAL_W:0]    bal_deb;
  logic [BAL_W:0]    bal_sum;

  // Beats follow grant combinationally: zero-cycle latency from grant.
  assign beat   = (state_q != IDLE) && bus.grant;
  assign refill = (ref_q == REF_LAST);

  // Balance: debit (floored at 1) first, then refill, then cap.
  always_comb begin
    bal_deb = {1'b0, bal_q};
    if (beat) begin
      bal_deb = (bal_q > BAL_W'(bid_q)) ? ({1'b0, bal_q} - (BAL_W+1)'(bid_q))
                                        : (BAL_W+1)'(1);
    end
    bal_sum = bal_deb + (refill ? AMT_X : '0);
    bal_d   = (refill && (bal_sum > CAP_X)) ? BAL_W'(BAL_CAP) : bal_sum[BAL_W-1:0];
    ref_d   = refill ? '0 : ref_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    spur_d  = (state_q == IDLE) && bus.grant;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d = BID;
          pri_d   = (bus.req_pri == '0) ? BID_W'(1) : bus.req_pri;
          rem_d   = (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
          wait_d  = '0;
        end
      end
      BID, XFER: begin
        if (beat) begin
          rem_d  = rem_q - 1'b1;
          wait_d = '0;
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = XFER;
          end
        end else begin
          // Pre-empted in XFER falls back to BID; only BID cycles count as waiting.
          state_d = BID;
          if ((state_q == BID) && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    starved_d = (wait_d == WAIT_MAX);
    ready_d   = (state_d == IDLE);

    // Bid is registered from next-state values so it is valid the cycle after accept.
    if (state_d == IDLE) begin
      bid_d = '0;
    end else if (starved_d && (bal_d > BID_MAX_BAL)) begin
      bid_d = '1;
    end else if (bal_d > BAL_W'(pri_d)) begin
      bid_d = pri_d;
    end else begin
      bid_d = BID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pri_q     <= '0;
      bid_q     <= '0;
      rem_q     <= '0;
      bal_q     <= BAL_W'(BAL_INIT);
      ref_q     <= '0;
      wait_q    <= '0;
      starved_q <= 1'b0;
      done_q    <= 1'b0;
      spur_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      bid_q     <= bid_d;
      rem_q     <= rem_d;
      bal_q     <= bal_d;
      ref_q     <= ref_d;
      wait_q    <= wait_d;
      starved_q <= starved_d;
      done_q    <= done_d;
      spur_q    <= spur_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.bid        = bid_q;
  assign bus.xfer_valid = beat;
  assign bus.xfer_last  = beat && (rem_q == LEN_W'(1));
  assign bus.done       = done_q;
  assign bus.starved    = starved_q;
  assign bus.spur_grant = spur_q;
  assign bus.balance    = bal_q;

endmodule

// File: tb/tb_bid_requester.sv
module tb_bid_requester;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bid_requester_if #(.BID_W(4), .LEN_W(4), .BAL_W(10)) bus ();

  bid_requester #(
    .BID_W(4), .LEN_W(4), .BAL_W(10), .BAL_INIT(750), .REFILL_PERIOD(400),
    .REFILL_AMT(750), .BAL_CAP(900), .STARVE_LIMIT(60)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks;
  int errors;

  // Reference model: transfer-level view of the requester.
  bit m_busy;        // a request is outstanding
  int m_rem;         // beats still to go
  int m_pri;         // effective priority
  int m_bal;         // balance
  int m_tick;        // cycles since last refill
  int m_wait;        // counted ungranted bidding cycles
  bit m_starved;
  bit m_after_beat;  // the first ungranted cycle right after a beat is not counted
  bit m_done;
  bit m_spur;

  function automatic int e_bid();
    if (!m_busy) return 0;
    if (m_starved && m_bal > 15) return 15;
    if (m_bal > m_pri) return m_pri;
    return 1;
  endfunction

  function automatic bit e_xv();
    return m_busy && bus.grant;
  endfunction

  function automatic bit e_xl();
    return m_busy && bus.grant && (m_rem == 1);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rem = 0; m_pri = 0; m_bal = 750; m_tick = 0; m_wait = 0;
    m_starved = 0; m_after_beat = 0; m_done = 0; m_spur = 0;
  endtask

  task automatic model_edge();
    bit beat;
    int b;
    beat   = m_busy && bus.grant;
    b      = e_bid();
    m_done = 0;
    m_spur = !m_busy && bus.grant;
    if (beat) m_bal = (m_bal - b < 1) ? 1 : m_bal - b;
    if (m_tick == 400) begin
      m_bal  = (m_bal + 750 > 900) ? 900 : m_bal + 750;
      m_tick = 0;
    end else begin
      m_tick++;
    end
    if (!m_busy) begin
      if (bus.req_valid) begin
        m_busy = 1;
        m_pri  = (bus.req_pri == 0) ? 1 : int'(bus.req_pri);
        m_rem  = (bus.req_len == 0) ? 1 : int'(bus.req_len);
        m_wait = 0; m_starved = 0; m_after_beat = 0;
      end
    end else if (beat) begin
      m_wait = 0; m_starved = 0; m_after_beat = 1;
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      if (m_after_beat) m_after_beat = 0;
      else if (m_wait < 60) m_wait++;
      m_starved = (m_wait >= 60);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_pri = 0; bus.req_len = 0; bus.grant = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", bus.req_ready); end
    checks++; if (bus.bid !== 4'd0) begin errors++; $display("FAIL reset_bid: got %0d expected 0", bus.bid); end
    checks++; if (bus.balance !== 10'd750) begin errors++; $display("FAIL reset_balance: got %0d expected 750", bus.balance); end
    checks++;
    if ({bus.xfer_valid, bus.xfer_last, bus.done, bus.starved, bus.spur_grant} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.xfer_valid, bus.xfer_last, bus.done, bus.starved, bus.spur_grant});
    end
    cycle();
  endtask

  task automatic test_basic();
    int beats = 0;
    int last_at = -1;
    bus.req_valid = 1; bus.req_pri = 5; bus.req_len = 3; bus.grant = 0;
    #1;
    checks++; if (bus.bid !== 4'd0) begin errors++; $display("FAIL basic_idle_bid: got %0d expected 0", bus.bid); end
    cycle();
    bus.req_valid = 0;
    for (int c = 0; c < 3; c++) begin
      bus.grant = 1;
      #1;
      if (bus.xfer_valid === 1'b1) beats++;
      if (bus.xfer_last === 1'b1) last_at = beats;
      checks++; if (bus.bid !== 4'd5) begin errors++; $display("FAIL basic_bid: got %0d expected 5", bus.bid); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %0d expected 0", bus.req_ready); end
      cycle();
    end
    bus.grant = 0;
    #1;
    checks++; if (beats != 3) begin errors++; $display("FAIL basic_beats: got %0d expected 3", beats); end
    checks++; if (last_at != 3) begin errors++; $display("FAIL basic_last: got %0d expected 3", last_at); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", bus.done); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0d expected 1", bus.req_ready); end
    checks++; if (bus.balance !== 10'd735) begin errors++; $display("FAIL basic_balance: got %0d expected 735", bus.balance); end
    cycle();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0d expected 0", bus.done); end
  endtask

  task automatic test_preempt();
    logic [6:0] pat = 7'b1100011;
    int beats = 0, lasts = 0, dones = 0;
    bus.req_valid = 1; bus.req_pri = 5; bus.req_len = 4; bus.grant = 0;
    #1;
    cycle();
    bus.req_valid = 0;
    for (int c = 0; c < 9; c++) begin
      bus.grant = (c < 7) ? pat[6-c] : 1'b0;
      #1;
      if (m_busy) begin
        checks++; if (bus.bid !== 4'd5) begin errors++; $display("FAIL preempt_bid: cycle %0d got %0d expected 5", c, bus.bid); end
      end
      checks++; if (bus.xfer_valid !== e_xv()) begin errors++; $display("FAIL preempt_xv: cycle %0d got %0d expected %0d", c, bus.xfer_valid, e_xv()); end
      if (bus.xfer_valid === 1'b1) beats++;
      if (bus.xfer_last === 1'b1) lasts++;
      if (bus.done === 1'b1) dones++;
      cycle();
    end
    checks++; if (beats != 4) begin errors++; $display("FAIL preempt_beats: got %0d expected 4", beats); end
    checks++; if (lasts != 1) begin errors++; $display("FAIL preempt_last: got %0d expected 1", lasts); end
    checks++; if (dones != 1) begin errors++; $display("FAIL preempt_done: got %0d expected 1", dones); end
  endtask

  task automatic test_starve();
    bus.req_valid = 1; bus.req_pri = 3; bus.req_len = 1; bus.grant = 0;
    #1;
    cycle();
    bus.req_valid = 0;
    for (int i = 0; i < 60; i++) begin
      bus.grant = 0;
      #1;
      checks++;
      if (bus.starved !== 1'b0 || bus.bid !== 4'd3) begin
        errors++;
        $display("FAIL starve_early: wait %0d got starved=%0d bid=%0d expected starved=0 bid=3", i, bus.starved, bus.bid);
      end
      cycle();
    end
    #1;
    checks++; if (bus.starved !== 1'b1) begin errors++; $display("FAIL starve_flag: got %0d expected 1", bus.starved); end
    checks++; if (bus.bid !== 4'd15) begin errors++; $display("FAIL starve_bid: got %0d expected 15", bus.bid); end
    bus.grant = 1;
    #1;
    checks++; if (bus.xfer_valid !== 1'b1) begin errors++; $display("FAIL starve_beat: got %0d expected 1", bus.xfer_valid); end
    cycle();
    bus.grant = 0;
    #1;
    checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL starve_clear: got %0d expected 0", bus.starved); end
    checks++; if (bus.balance !== 10'(m_bal)) begin errors++; $display("FAIL starve_balance: got %0d expected %0d", bus.balance, m_bal); end
    cycle();
  endtask

  task automatic test_spur();
    idle_inputs();
    bus.grant = 1;
    #1;
    checks++; if (bus.xfer_valid !== 1'b0) begin errors++; $display("FAIL spur_no_beat: got %0d expected 0", bus.xfer_valid); end
    cycle();
    bus.grant = 0;
    #1;
    checks++; if (bus.spur_grant !== 1'b1) begin errors++; $display("FAIL spur_pulse: got %0d expected 1", bus.spur_grant); end
    checks++; if (bus.balance !== 10'(m_bal)) begin errors++; $display("FAIL spur_balance: got %0d expected %0d", bus.balance, m_bal); end
    cycle();
    checks++; if (bus.spur_grant !== 1'b0) begin errors++; $display("FAIL spur_end: got %0d expected 0", bus.spur_grant); end
  endtask

  task automatic test_floor();
    int floor_beats = 0;
    int n = 0;
    while (floor_beats < 5 && n < 3000) begin
      bus.grant = 1; bus.req_valid = 1; bus.req_pri = 9; bus.req_len = 15;
      #1;
      checks++; if (bus.balance !== 10'(m_bal)) begin errors++; $display("FAIL floor_balance: got %0d expected %0d", bus.balance, m_bal); end
      checks++; if (bus.bid !== 4'(e_bid())) begin errors++; $display("FAIL floor_bid: got %0d expected %0d (balance %0d)", bus.bid, e_bid(), m_bal); end
      if (m_busy && m_bal == 1) floor_beats++;
      cycle();
      n++;
    end
    checks++; if (floor_beats < 5) begin errors++; $display("FAIL floor_reached: got %0d beats at floor expected 5", floor_beats); end
    idle_inputs();
    while (m_busy && n < 3100) begin
      bus.grant = 1;
      #1;
      cycle();
      n++;
    end
    bus.grant = 0;
    #1;
    checks++; if (bus.balance !== 10'(m_bal)) begin errors++; $display("FAIL floor_end_balance: got %0d expected %0d", bus.balance, m_bal); end
    cycle();
  endtask

  task automatic drain_to(input int target, output bit ok);
    int n = 0;
    int d;
    ok = 0;
    while (n < 2000) begin
      d = m_bal - target;
      if (!m_busy && d == 0) begin
        ok = 1;
        break;
      end
      bus.grant     = m_busy;
      bus.req_valid = !m_busy && d > 0;
      bus.req_pri   = 4'((d > 15) ? 15 : ((d > 0) ? d : 1));
      bus.req_len   = 1;
      #1;
      cycle();
      n++;
    end
    idle_inputs();
  endtask

  task automatic wait_tick(input int target, output bit ok);
    int n = 0;
    idle_inputs();
    while (m_tick != target && n < 1000) begin
      #1;
      cycle();
      n++;
    end
    ok = (m_tick == target);
  endtask

  task automatic test_refill();
    bit ok1, ok2;
    int starts [2] = '{300, 100};
    int ends [2] = '{900, 850};
    for (int k = 0; k < 2; k++) begin
      drain_to(starts[k], ok1);
      wait_tick(400, ok2);
      checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL refill_setup_%0d: got drain=%0d tick=%0d expected 1 1", k, ok1, ok2); end
      checks++; if (bus.balance !== 10'(starts[k])) begin errors++; $display("FAIL refill_pre_%0d: got %0d expected %0d", k, bus.balance, starts[k]); end
      #1;
      cycle();
      checks++; if (bus.balance !== 10'(ends[k])) begin errors++; $display("FAIL refill_post_%0d: got %0d expected %0d", k, bus.balance, ends[k]); end
    end
    // Debit and refill on the same edge: 850 - 15 + 750 capped at 900.
    wait_tick(399, ok2);
    bus.req_valid = 1; bus.req_pri = 15; bus.req_len = 1; bus.grant = 0;
    #1;
    cycle();
    bus.req_valid = 0; bus.grant = 1;
    #1;
    checks++; if (bus.xfer_valid !== 1'b1 || !ok2) begin errors++; $display("FAIL refill_same_beat: got %0d expected 1", bus.xfer_valid); end
    cycle();
    bus.grant = 0;
    #1;
    checks++; if (bus.balance !== 10'd900) begin errors++; $display("FAIL refill_same_edge: got %0d expected 900", bus.balance); end
    checks++; if (bus.balance !== 10'(m_bal)) begin errors++; $display("FAIL refill_same_model: got %0d expected %0d", bus.balance, m_bal); end
    cycle();
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1; bus.req_pri = 5; bus.req_len = 6; bus.grant = 0;
    #1;
    cycle();
    bus.req_valid = 0;
    for (int c = 0; c < 2; c++) begin
      bus.grant = 1;
      #1;
      cycle();
    end
    #1;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.req_ready, bus.bid, bus.xfer_valid, bus.xfer_last, bus.done, bus.starved, bus.spur_grant} !== 10'b1_0000_00000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected 1000000000",
               {bus.req_ready, bus.bid, bus.xfer_valid, bus.xfer_last, bus.done, bus.starved, bus.spur_grant});
    end
    checks++; if (bus.balance !== 10'd750) begin errors++; $display("FAIL midreset_balance: got %0d expected 750", bus.balance); end
    @(posedge clk);
    #1;
    bus.grant = 0;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", bus.done); end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    int gprob = 90;
    for (int c = 0; c < 900; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: gprob = 90;
          1: gprob = 50;
          default: gprob = 2;
        endcase
      end
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_pri   = 4'($urandom_range(0, 15));
      bus.req_len   = 4'($urandom_range(0, 15));
      bus.grant     = ($urandom_range(0, 99) < gprob);
      #1;
      got = {bus.req_ready, bus.bid, bus.xfer_valid, bus.xfer_last, bus.done, bus.starved, bus.spur_grant, bus.balance};
      exp = {!m_busy, 4'(e_bid()), e_xv(), e_xl(), m_done, m_starved, m_spur, 10'(m_bal)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h expected %h", c, got, exp);
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    test_reset();
    test_basic();
    test_preempt();
    test_starve();
    test_spur();
    test_floor();
    test_refill();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
